// File: rtl/fp_argmax.sv
// fp_argmax: streaming IEEE-style float argmax/argmin over a valid/ready vector stream.
module fp_argmax #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int VEC_LEN = 10,
  parameter int IDX_W   = 4,
  parameter bit MODE    = 1'b0
) (
  input  logic                     input_clk,
  input  logic                     input_rst_n,
  input  logic                     input_valid,
  output logic                     output_ready,
  input  logic [EXP_W+MAN_W:0]     input_data,
  input  logic                     input_last,
  output logic                     output_valid,
  input  logic                     input_ready,
  output logic [IDX_W-1:0]         output_index,
  output logic [EXP_W+MAN_W:0]     output_value,
  output logic                     output_all_nan,
  output logic                     output_len_error
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(VEC_LEN - 1);

  typedef enum logic {ACC, HOLD} state_t;
  state_t state, nxt;

  logic             en, have_best, acc, vend, is_nan, upd, nb_have, at_max;
  logic [IDX_W-1:0] cnt, best_idx, nb_idx;
  logic [W-1:0]     best_val, nb_val;

  // Signed zeros collapse to +0 so -0 and +0 compare equal.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic sa, sb;
    sa = a[W-1] && (a[W-2:0] != '0);
    sb = b[W-1] && (b[W-2:0] != '0);
    if (sa != sb) return sb;
    return sa ? (a[W-2:0] < b[W-2:0]) : (a[W-2:0] > b[W-2:0]);
  endfunction

  assign output_ready = (state == ACC) && input_rst_n && en;
  assign output_valid = (state == HOLD);
  assign acc          = input_valid && output_ready;
  assign at_max       = (cnt == CNT_MAX);
  assign vend         = acc && (input_last || at_max);
  assign is_nan       = (&input_data[W-2:MAN_W]) && (|input_data[MAN_W-1:0]);
  assign upd          = acc && !is_nan &&
                        (!have_best || (MODE ? gt(best_val, input_data) : gt(input_data, best_val)));
  assign nb_have      = have_best || upd;
  assign nb_val       = upd ? input_data : best_val;
  assign nb_idx       = upd ? cnt : best_idx;

  always_comb begin
    nxt = state;
    if (state == ACC) nxt = vend ? HOLD : ACC;
    else nxt = input_ready ? ACC : HOLD;
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) state <= ACC;
    else state <= nxt;
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      en               <= 1'b0;
      cnt              <= '0;
      have_best        <= 1'b0;
      best_val         <= '0;
      best_idx         <= '0;
      output_index     <= '0;
      output_value     <= '0;
      output_all_nan   <= 1'b0;
      output_len_error <= 1'b0;
    end else begin
      en <= 1'b1;
      if (vend) begin
        cnt              <= '0;
        have_best        <= 1'b0;
        output_index     <= nb_have ? nb_idx : '0;
        output_value     <= nb_have ? nb_val : QNAN;
        output_all_nan   <= !nb_have;
        output_len_error <= !(input_last && at_max);
      end else if (acc) begin
        cnt       <= cnt + 1'b1;
        have_best <= nb_have;
        best_val  <= nb_val;
        best_idx  <= nb_idx;
      end else if (output_valid && input_ready) begin
        output_all_nan   <= 1'b0;
        output_len_error <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fp_argmax.md
# fp_argmax

Streaming floating-point argmax/argmin reduction unit. It accepts one IEEE-754-style value per cycle over a valid/ready handshake and tracks the running best value and its index. When a vector ends it emits the winner. It sits after the output layer of the network to turn class scores into a class index, and generalises the single-pair float compare to parametrised formats, min/max mode, NaN and signed-zero handling, and multi-element sequencing.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, mantissa width; element width W = 1+EXP_W+MAN_W
- VEC_LEN, 10, maximum elements per vector (≥2)
- IDX_W, 4, index width (≥ clog2(VEC_LEN))
- MODE, 0, 0 = argmax, 1 = argmin

Ports:
- input_clk  in  1  clock; all state on rising edge
- input_rst_n  in  1  asynchronous, active-low reset
- input_valid  in  1  upstream element valid
- output_ready  out  1  block can accept an element
- input_data  in  W  element {sign, exp, mantissa}
- input_last  in  1  final element of vector
- output_valid  out  1  result valid
- input_ready  in  1  downstream accepts result
- output_index  out  IDX_W  position of winner within vector (0-based)
- output_value  out  W  winning element, raw bits
- output_all_nan  out  1  every element was NaN
- output_len_error  out  1  vector length ≠ VEC_LEN

## Operation
- Two states: ACC (collecting) and HOLD (result presented). Reset state is ACC.
- output_ready = (state==ACC) && input_rst_n. Beat accepted when input_valid && output_ready.
- NaN: exp all ones and mantissa ≠ 0. A NaN never becomes best.
- Ordering for non-NaN values: sign/magnitude total order, +0 == −0, and ±inf ordered normally. Subnormals are compared by raw magnitude bits.
- Replacement rule on each accepted non-NaN beat:
  - Replace if no best is held yet.
  - Otherwise replace if strictly greater (MODE 0) or strictly less (MODE 1).
  - Ties keep the earlier index.
- Element counter cnt (0..VEC_LEN-1) increments per accepted beat.
- Vector ends on the accepted beat with input_last=1 or cnt==VEC_LEN-1, whichever comes first.
  - output_len_error = 1 unless both conditions hold on the same beat.
- On vector end, the block registers the result and moves to HOLD.
- All-NaN result: output_all_nan=1, output_index=0, output_value = canonical qNaN {0, all ones, 1, zeros}.
- In HOLD, outputs stay stable. When output_valid && input_ready:
  - return to ACC;
  - clear cnt, have_best and the flags.
- input_data/input_last are ignored when not accepted.
- Reset (any time, including mid-vector or in HOLD) asynchronously returns to ACC, discards partial vector and pending result.
- Reset values: output_valid 0, output_index 0, output_value 0, output_all_nan 0, output_len_error 0; output_ready 0 while reset asserted, 1 from first edge after release.

## Timing
- Throughput one element per cycle within a vector; compare and update complete in the accepting cycle.
- Latency: output_valid rises in the cycle after the last beat is accepted.
- Between vectors: output_ready is low for at least the one HOLD cycle; the next vector's first beat is acceptable in the cycle after the result handshake.
- Result handshake completes on any edge with output_valid && input_ready; output_valid drops the next cycle.
- Backpressure: with input_ready low, HOLD persists indefinitely and all outputs stay constant.

## Test plan
- MODE=0, VEC_LEN=4. Stimulus: 0x3F800000, 0x40400000, 0xC0A00000, 0x40000000, with last on the 4th beat, back-to-back. Required: output_valid one cycle later, index 1, value 0x40400000, len_error 0, all_nan 0.
- MODE=1 instance, same vector -> index 2, value 0xC0A00000.
- Zeros and ties, MODE=0. Stimulus: 0x80000000, 0x00000000, 0xBF800000, 0x80000000 -> index 0, value 0x80000000.
- NaN handling, MODE=0.
  - Stimulus: 0x7FC00000, 0xFF800000, 0x7FC00001, 0xC0000000 -> index 3, value 0xC0000000.
  - All four elements 0x7FC00000 -> all_nan 1, index 0, value 0x7FC00000.
- Length and backpressure, VEC_LEN=4.
  - Last on beat 2 of (1.0, 3.0) -> index 1, len_error 1.
  - Six beats with no last -> terminates after beat 4, len_error 1, output_ready 0 on beat 5.
  - Hold input_ready low for 3 cycles -> outputs unchanged throughout.
- Reset mid-vector. Assert input_rst_n low after 2 beats -> output_ready and output_valid go 0 immediately. After release, a full 4-element vector gives a result with indices counted from 0.
